// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: tracks pending writes and pending loads per
// architectural register and gates issue on load-use and pending-count saturation.
module id_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_WB     = 2,
    parameter int CNT_W      = 2,
    parameter int PERF_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         id_valid,
    input  logic [REG_ADDR_W-1:0]        id_rs1,
    input  logic                         id_rs1_en,
    input  logic [REG_ADDR_W-1:0]        id_rs2,
    input  logic                         id_rs2_en,
    input  logic [REG_ADDR_W-1:0]        id_rd,
    input  logic                         id_rd_en,
    input  logic                         id_is_load,
    output logic                         id_ready,
    output logic                         issue,
    input  logic [NUM_WB-1:0]            wb_valid,
    input  logic [NUM_WB*REG_ADDR_W-1:0] wb_addr,
    input  logic [NUM_WB-1:0]            wb_is_load,
    output logic [PERF_W-1:0]            stall_cycles,
    output logic                         underflow_err
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;
    localparam int DEC_W    = $clog2(NUM_WB + 1);
    localparam int SUM_W    = CNT_W + DEC_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic             uflow;
        logic [CNT_W-1:0] cnt;
    } cnt_upd_t;

    logic [CNT_W-1:0]  pend_q [NUM_REGS];
    logic [CNT_W-1:0]  pend_d [NUM_REGS];
    logic [CNT_W-1:0]  load_q [NUM_REGS];
    logic [CNT_W-1:0]  load_d [NUM_REGS];
    logic [DEC_W-1:0]  pend_dec [NUM_REGS];
    logic [DEC_W-1:0]  load_dec [NUM_REGS];
    cnt_upd_t          pend_upd [NUM_REGS];
    cnt_upd_t          load_upd [NUM_REGS];
    logic [PERF_W-1:0] stall_q, stall_d;
    logic              uflow_q, uflow_d;
    logic              rs1_haz, rs2_haz, rd_haz;

    // Increment is applied before the completions so an issue and a completion to
    // the same register in one cycle net out without flagging underflow.
    function automatic cnt_upd_t cnt_step(input logic [CNT_W-1:0] cnt,
                                          input logic             inc,
                                          input logic [DEC_W-1:0] dec);
        cnt_upd_t         res;
        logic [SUM_W-1:0] up;
        up = SUM_W'(cnt) + SUM_W'(inc);
        if (up > SUM_W'(CNT_MAX)) up = SUM_W'(CNT_MAX);
        if (up < SUM_W'(dec)) begin
            res.uflow = 1'b1;
            res.cnt   = '0;
        end else begin
            res.uflow = 1'b0;
            res.cnt   = CNT_W'(up - SUM_W'(dec));
        end
        return res;
    endfunction

    assign rs1_haz  = id_rs1_en && (id_rs1 != '0) && (load_q[id_rs1] != '0);
    assign rs2_haz  = id_rs2_en && (id_rs2 != '0) && (load_q[id_rs2] != '0);
    assign rd_haz   = id_rd_en  && (id_rd  != '0) && (pend_q[id_rd] == CNT_MAX);
    assign id_ready = !(rs1_haz || rs2_haz || rd_haz);
    assign issue    = id_valid && id_ready;

    // NOTE: every comb-assigned variable gets a default first so no latch is inferred.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_dec[r] = '0;
            load_dec[r] = '0;
        end
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_valid[i] && (wb_addr[i*REG_ADDR_W +: REG_ADDR_W] != '0)) begin
                pend_dec[wb_addr[i*REG_ADDR_W +: REG_ADDR_W]] =
                    pend_dec[wb_addr[i*REG_ADDR_W +: REG_ADDR_W]] + DEC_W'(1);
                if (wb_is_load[i])
                    load_dec[wb_addr[i*REG_ADDR_W +: REG_ADDR_W]] =
                        load_dec[wb_addr[i*REG_ADDR_W +: REG_ADDR_W]] + DEC_W'(1);
            end
        end
    end

    always_comb begin
        uflow_d = uflow_q;
        stall_d = stall_q + PERF_W'(id_valid && !id_ready && !flush);
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_upd[r] = cnt_step(pend_q[r],
                                   issue && id_rd_en && (id_rd != '0) && (id_rd == REG_ADDR_W'(r)),
                                   pend_dec[r]);
            load_upd[r] = cnt_step(load_q[r],
                                   issue && id_rd_en && id_is_load && (id_rd != '0) &&
                                   (id_rd == REG_ADDR_W'(r)),
                                   load_dec[r]);
            pend_d[r]   = pend_upd[r].cnt;
            load_d[r]   = load_upd[r].cnt;
            uflow_d     = uflow_d | pend_upd[r].uflow | load_upd[r].uflow;
        end
        if (flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_d[r] = '0;
                load_d[r] = '0;
            end
            uflow_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: the counter arrays live in flops and must be reset; stale counts would stall decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_q[r] <= '0;
                load_q[r] <= '0;
            end
            stall_q <= '0;
            uflow_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_q[r] <= pend_d[r];
                load_q[r] <= load_d[r];
            end
            stall_q <= stall_d;
            uflow_q <= uflow_d;
        end
    end

    assign stall_cycles  = stall_q;
    assign underflow_err = uflow_q;

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Parametrised register scoreboard and issue gate for the decode stage. It tracks outstanding destination writes and outstanding loads per architectural register. It holds an instruction in decode while a source depends on an in-flight load, or while its destination's pending-write count is saturated. It sits between the decode logic and the id/ex pipeline register, replacing ad-hoc load-use detection. It also maintains a stall performance counter and a sticky underflow error flag.

## Interface
- REG_ADDR_W, 5: register address width; 2**REG_ADDR_W registers tracked.
- NUM_WB, 2: number of independent writeback/completion ports.
- CNT_W, 2: per-register pending counter width; saturation value 2**CNT_W-1.
- PERF_W, 32: stall counter width.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline squash; clears all tracking state.
- id_valid  in  1  decoded instruction present.
- id_rs1, id_rs2  in  REG_ADDR_W  source register addresses.
- id_rs1_en, id_rs2_en  in  1  source actually read.
- id_rd  in  REG_ADDR_W  destination register.
- id_rd_en  in  1  instruction writes id_rd.
- id_is_load  in  1  instruction is LB/LH/LW/LBU/LHU.
- id_ready  out  1  instruction may issue this cycle (combinational).
- issue  out  1  id_valid & id_ready.
- wb_valid  in  NUM_WB  completion on port i.
- wb_addr  in  NUM_WB*REG_ADDR_W  completed destination, port i at [i*REG_ADDR_W +: REG_ADDR_W].
- wb_is_load  in  NUM_WB  completion is a load result.
- stall_cycles  out  PERF_W  cycles with id_valid & !id_ready.
- underflow_err  out  1  sticky; a completion hit a zero counter.

## Operation
- State per register r (r != 0): pend_cnt[r] (CNT_W bits) and load_cnt[r] (CNT_W bits). Register 0 is never tracked; its counters read as 0.
- Hazards:
  - src hazard: rsN_en & rsN != 0 & load_cnt[rsN] != 0.
  - dst hazard: id_rd_en & id_rd != 0 & pend_cnt[id_rd] == max.
  - id_ready = !(rs1 hazard | rs2 hazard | dst hazard), independent of id_valid.
- Non-load pending writes never stall; downstream forwarding covers them.
- On issue with id_rd_en and id_rd != 0: pend_cnt[id_rd] +1. If id_is_load, load_cnt[id_rd] +1 as well.
- On each wb_valid[i] with wb_addr[i] != 0: pend_cnt -1. If wb_is_load[i], load_cnt -1 as well.
- Net update per register each cycle = issue increments minus the sum of all matching completions, applied in one step. Multiple ports on the same address decrement once each.
- Underflow: a decrement that would take a counter below 0 clamps that counter to 0 and sets underflow_err. Only flush or rst clears underflow_err.
- id_is_load with !id_rd_en or id_rd == 0 does not touch any counter.
- flush: next edge zeroes all pend_cnt/load_cnt. Same-cycle issue and completions are discarded. stall_cycles is unaffected.
- stall_cycles increments while id_valid & !id_ready & !flush, and wraps at 2**PERF_W.

## Timing
- id_ready and issue are combinational from the current counters and id_* inputs; no same-cycle bypass from wb.
- A completion in cycle N releases a load-use stall at cycle N+1.
- Counter updates take effect at the edge ending the cycle of issue/wb; latency 1.
- Reset values: all counters 0, stall_cycles 0, underflow_err 0. id_ready is then 1 for any input, since no counter is nonzero.
- Reset mid-operation overrides flush, issue and wb in the same cycle.
- Priority at an edge: rst > flush > counter arithmetic.

## Test plan
- Load-use stall: issue LW x5 (is_load, rd=5); next cycle ADD rs1=5 -> id_ready=0. Stall persists; wb_valid[0]=1, wb_addr=5, wb_is_load=1 at cycle N -> id_ready=1 at N+1, stall_cycles=number of stalled valid cycles.
- ALU dependence: issue ADDI x3, then ADD rs1=3 -> id_ready=1 immediately; pend_cnt[3]=1 until wb, then 0.
- Saturation: CNT_W=2; issue three writes to x7 without completion -> fourth write to x7 has id_ready=0; one wb to x7 -> ready next cycle.
- Simultaneous: issue LW x9 in the same cycle as wb of an earlier load x9 -> load_cnt[9] unchanged at 1. Two ports completing x4 (cnt=2) together -> cnt 0.
- x0 and underflow: LW x0 then use rs1=0 -> no stall. wb to x12 with cnt 0 -> underflow_err=1, counters stay 0.
- Flush and reset: fill several counters, assert flush -> all ready, underflow_err=0, stall_cycles held. Assert rst mid-stall -> stall_cycles=0, id_ready=1 next cycle.
